bandai2003_eeprom_ctrl: RTL and testbench
=========================================

Name: bandai2003_eeprom_ctrl

Overview:
- Serial EEPROM controller for the BANDAI2003 cartridge mapper. It maps to I/O ports C4h-C8h, alongside the mapper's bank registers C0h-C3h.
- It takes a command word and data from the console bus and sequences a Microwire (93Cxx, x16) EEPROM: chip select, clock, shift-out, shift-in, then ready polling after writes.
- The top level gates SEL with the mapper's unlock decode and muxes DOUT onto DQ.

Parameters:
- CLK_DIV, 4: CLK cycles per EESK half-period; also the EECS-low gap. Minimum 1.
- CMD_BITS, 11: command length shifted from CMD[CMD_BITS-1:0] (start + opcode + address). Range 3..16.
- POLL_MAX, 4096: ready-poll timeout in CLK cycles. Used only with EEP_POLL_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock; every input is synchronous to it.
- RSTn  in  1  reset, asynchronous, active-low.
- SEL  in  1  port-space select (unlocked and I/O cycle), active high.
- WEn  in  1  bus write strobe, active low.
- OEn  in  1  bus read strobe, active low.
- ADDR  in  8  I/O port address.
- DIN  in  8  bus write data.
- DOUT  out  8  bus read data.
- DOE  out  1  DOUT drive enable.
- EECS  out  1  EEPROM chip select, active high.
- EESK  out  1  EEPROM serial clock.
- EEDI  out  1  serial data to EEPROM.
- EEDO  in  1  serial data from EEPROM; doubles as the ready/busy line.

Behaviour:
- Reset: DATA=0000h, CMD=0000h, all flags 0, state IDLE, EECS/EESK/EEDI=0, DOE=0, DOUT=00h.
- Write strobe: a one-cycle pulse when SEL=1, WEn=0 and the registered WEn=1 (falling edge). DIN and ADDR are sampled in that cycle.
- Register map:
  - C4h: DATA[7:0].
  - C5h: DATA[15:8].
  - C6h: CMD[7:0].
  - C7h: CMD[15:8].
  - C8h write: bit4 READ, bit5 WRITE, bit6 SHORT (EWEN/EWDS/ERASE/ERAL), bit7 ABORT.
  - C8h read: bit0 RDONE, bit1 READY (state==IDLE), bit2 ERR, all other bits 0.
- Bus read path: DOE = SEL & ~OEn & WEn & ADDR in C4h..C8h, combinational. DOUT = selected register when DOE=1, else 00h.
- Writes to C4h-C7h are ignored when not IDLE.
- Starting an operation:
  - A C8h write in IDLE with exactly one of bits 4/5/6 set clears RDONE and ERR, latches the op, and sets EECS=1 the next cycle.
  - Zero or multiple bits set: no start, no flag change.
  - A start request while busy is ignored.
- ABORT (bit7) in any state has priority over start bits. Next cycle: EECS=EESK=EEDI=0, IDLE; DATA unchanged, RDONE stays 0.
- Bit timing for every shifted bit:
  - EEDI is driven while EESK=0.
  - EESK is held 0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - EEDO is sampled on the CLK edge where EESK rises.
  - Shifting is MSB-first.
- States:
  - IDLE: all EEPROM outputs 0.
  - CMD: CMD_BITS pulses from CMD[CMD_BITS-1] downward. Then READ goes to RDATA, WRITE goes to WDATA, SHORT goes to GAP.
  - RDATA: 16 pulses shifted into a private shift register. On the 16th, DATA is loaded from it and RDONE is set, then GAP.
  - WDATA: 16 pulses from DATA[15] downward, then WGAP.
  - WGAP: EECS=0 for CLK_DIV cycles, then EECS=1, then POLL.
  - POLL: EESK=0. When EEDO=1, go to GAP.
  - GAP: EECS=0, EEDI=0 for CLK_DIV cycles, then IDLE (READY=1).
- Operation lengths:
  - Read: CMD_BITS+16 pulses.
  - Short: CMD_BITS pulses.
  - Write: CMD_BITS+16 pulses plus the poll phase.
- Reset mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- EEP_POLL_TIMEOUT_EN defined:
  - A counter runs in POLL.
  - If EEDO is still 0 after POLL_MAX cycles, ERR is set and the block goes to GAP, then IDLE.
- EEP_POLL_TIMEOUT_EN undefined:
  - POLL waits indefinitely; only ABORT or reset exit it.
  - ERR always reads 0 and POLL_MAX is unused.

Test Plan (CLK_DIV=2, CMD_BITS=11):
1. Reset release -> EECS/EESK/EEDI=0; C8h reads 02h; C4h-C7h read 00h; DOE=0 without OEn.
2. Read: write C6h=05h, C7h=06h, C8h=10h; EEPROM model returns BEEFh.
   - Response: 27 EESK pulses, each 4 CLK.
   - EEDI during CMD = 1,1,0,0,0,0,0,0,1,0,1.
   - Afterwards C4h=EFh, C5h=BEh, C8h=03h.
3. Write: write C4h=34h, C5h=12h, C6h=03h, C7h=05h, C8h=20h; EEDO low for 50 CLK in POLL, then high.
   - Response: EEDI data bits = 1234h MSB-first.
   - EECS low 2 CLK before POLL.
   - READY returns after EEDO rises; C8h=02h.
4. Timeout (EEP_POLL_TIMEOUT_EN, POLL_MAX=64), same write with EEDO stuck 0.
   - Response: ERR set after 64 POLL cycles; C8h=06h; EECS=0.
   - Without the macro: still busy after 10000 CLK.
5. Abort: start the read from scenario 2, then write C8h=80h after 5 EESK pulses.
   - Response: next CLK EECS=EESK=0; C8h=02h; C4h/C5h keep prior values.
6. Illegal and busy cases.
   - C8h=30h in IDLE: no EECS assertion, C8h stays 02h.
   - C4h=AAh written during an active read: ignored; C4h shows the read result.

Source files
------------

// File: rtl/bandai2003_eeprom_ctrl_if.sv
// Console-side I/O bus of the BANDAI2003 EEPROM controller.
// The mapper/console side uses the master modport, the controller the slave modport.
interface bandai2003_eeprom_ctrl_if;
    logic       SEL;
    logic       WEn;
    logic       OEn;
    logic [7:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       DOE;

    modport master (
        output SEL, WEn, OEn, ADDR, DIN,
        input  DOUT, DOE
    );

    modport slave (
        input  SEL, WEn, OEn, ADDR, DIN,
        output DOUT, DOE
    );
endinterface

// File: rtl/bandai2003_eeprom_ctrl.sv
// BANDAI2003 mapper serial EEPROM controller (ports C4h-C8h).
// Sequences a Microwire 93Cxx (x16) part: command shift, data shift in/out,
// and ready polling after writes.
// Optional: define EEP_POLL_TIMEOUT_EN to abort the ready poll after POLL_MAX
// cycles and flag ERR; without it the poll waits until EEDO rises or ABORT.
module bandai2003_eeprom_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int CMD_BITS = 11,
    parameter int POLL_MAX = 4096
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    bandai2003_eeprom_ctrl_if.slave        bus,
    output logic                           EECS,
    output logic                           EESK,
    output logic                           EEDI,
    input  logic                           EEDO
);

    localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam int                POLL_W    = $clog2(POLL_MAX + 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
    localparam logic [3:0]        CMD_MSB   = 4'(CMD_BITS - 1);

    localparam logic [7:0] A_DLO = 8'hC4;
    localparam logic [7:0] A_DHI = 8'hC5;
    localparam logic [7:0] A_CLO = 8'hC6;
    localparam logic [7:0] A_CHI = 8'hC7;
    localparam logic [7:0] A_CTL = 8'hC8;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_SHORT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_WGAP  = 3'd4,
        ST_POLL  = 3'd5,
        ST_GAP   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                phase_q, phase_d;     // EESK level of the current bit
    logic [3:0]          bit_q, bit_d;         // index of the bit being shifted
    logic [1:0]          op_q, op_d;
    logic [15:0]         rsh_q, rsh_d;         // read shift register
    logic [15:0]         data_q, data_d;
    logic [15:0]         cmd_q, cmd_d;
    logic                rdone_q, rdone_d;
    logic                err_q, err_d;
    logic [POLL_W-1:0]   poll_q, poll_d;       // cycles spent in POLL
    logic                wen_q, wen_d;
    logic                eecs_q, eecs_d;
    logic                eesk_q, eesk_d;
    logic                eedi_q, eedi_d;

    logic                wr_stb_s;
    logic                wr_ctl_s;
    logic                abort_s;
    logic                onehot_s;
    logic                start_s;
    logic                div_last_s;
    logic                doe_s;
    logic [7:0]          dout_s;

    assign wr_stb_s   = bus.SEL & ~bus.WEn & wen_q;
    assign wr_ctl_s   = wr_stb_s & (bus.ADDR == A_CTL);
    assign abort_s    = wr_ctl_s & bus.DIN[7];
    assign onehot_s   = (bus.DIN[6:4] == 3'b001) | (bus.DIN[6:4] == 3'b010) |
                        (bus.DIN[6:4] == 3'b100);
    assign start_s    = wr_ctl_s & ~bus.DIN[7] & onehot_s & (state_q == ST_IDLE);
    assign div_last_s = (div_q == DIV_LAST);

    // State and datapath registers, with asynchronous reset to the idle state.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= 4'd0;
            op_q    <= 2'd0;
            rsh_q   <= 16'h0000;
            data_q  <= 16'h0000;
            cmd_q   <= 16'h0000;
            rdone_q <= 1'b0;
            err_q   <= 1'b0;
            poll_q  <= '0;
            wen_q   <= 1'b1;
            eecs_q  <= 1'b0;
            eesk_q  <= 1'b0;
            eedi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            op_q    <= op_d;
            rsh_q   <= rsh_d;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
            rdone_q <= rdone_d;
            err_q   <= err_d;
            poll_q  <= poll_d;
            wen_q   <= wen_d;
            eecs_q  <= eecs_d;
            eesk_q  <= eesk_d;
            eedi_q  <= eedi_d;
        end
    end

    // Next-state logic: register writes, op start/abort, bit sequencing and polling.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        op_d    = op_q;
        rsh_d   = rsh_q;
        data_d  = data_q;
        cmd_d   = cmd_q;
        rdone_d = rdone_q;
        err_d   = err_q;
        poll_d  = poll_q;
        wen_d   = bus.WEn;
        if (abort_s) begin
            // ABORT beats any start bit and drops the EEPROM lines next cycle
            state_d = ST_IDLE;
            div_d   = '0;
            phase_d = 1'b0;
            bit_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_stb_s) begin
                        case (bus.ADDR)
                            A_DLO:   data_d[7:0]  = bus.DIN;
                            A_DHI:   data_d[15:8] = bus.DIN;
                            A_CLO:   cmd_d[7:0]   = bus.DIN;
                            A_CHI:   cmd_d[15:8]  = bus.DIN;
                            default: cmd_d        = cmd_q;
                        endcase
                    end else begin
                        cmd_d = cmd_q;
                    end
                    if (start_s) begin
                        state_d = ST_CMD;
                        div_d   = '0;
                        phase_d = 1'b0;
                        bit_d   = CMD_MSB;
                        rdone_d = 1'b0;
                        err_d   = 1'b0;
                        op_d    = bus.DIN[4] ? OP_READ : (bus.DIN[5] ? OP_WRITE : OP_SHORT);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD, ST_RDATA, ST_WDATA: begin
                    if (!div_last_s) begin
                        div_d = div_q + DIV_W'(1);
                    end else if (!phase_q) begin
                        // EESK rises on this edge: sample EEDO now
                        div_d   = '0;
                        phase_d = 1'b1;
                        if (state_q == ST_RDATA) begin
                            rsh_d = {rsh_q[14:0], EEDO};
                        end else begin
                            rsh_d = rsh_q;
                        end
                    end else if (bit_q != 4'd0) begin
                        div_d   = '0;
                        phase_d = 1'b0;
                        bit_d   = bit_q - 4'd1;
                    end else begin
                        div_d   = '0;
                        phase_d = 1'b0;
                        bit_d   = 4'd15;
                        case (state_q)
                            ST_CMD: begin
                                case (op_q)
                                    OP_READ:  state_d = ST_RDATA;
                                    OP_WRITE: state_d = ST_WDATA;
                                    default:  state_d = ST_GAP;
                                endcase
                            end
                            ST_RDATA: begin
                                data_d  = rsh_q;
                                rdone_d = 1'b1;
                                state_d = ST_GAP;
                            end
                            default: state_d = ST_WGAP;
                        endcase
                    end
                end
                ST_WGAP: begin
                    if (div_last_s) begin
                        div_d   = '0;
                        poll_d  = '0;
                        state_d = ST_POLL;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_POLL: begin
                    if (EEDO) begin
                        div_d   = '0;
                        state_d = ST_GAP;
`ifdef EEP_POLL_TIMEOUT_EN
                    end else if (poll_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        div_d   = '0;
                        state_d = ST_GAP;
`endif
                    end else begin
                        // saturating, so the idle build never wraps
                        poll_d = (poll_q == POLL_LAST) ? poll_q : poll_q + POLL_W'(1);
                    end
                end
                ST_GAP: begin
                    if (div_last_s) begin
                        div_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: next EEPROM pin levels (registered) and the bus read mux.
    always_comb begin
        eecs_d = 1'b0;
        eesk_d = 1'b0;
        eedi_d = 1'b0;
        case (state_d)
            ST_CMD: begin
                eecs_d = 1'b1;
                eesk_d = phase_d;
                eedi_d = cmd_q[bit_d];
            end
            ST_RDATA: begin
                eecs_d = 1'b1;
                eesk_d = phase_d;
            end
            ST_WDATA: begin
                eecs_d = 1'b1;
                eesk_d = phase_d;
                eedi_d = data_q[bit_d];
            end
            ST_POLL: eecs_d = 1'b1;
            default: eecs_d = 1'b0;
        endcase

        doe_s  = bus.SEL & ~bus.OEn & bus.WEn &
                 (bus.ADDR >= A_DLO) & (bus.ADDR <= A_CTL);
        dout_s = 8'h00;
        if (doe_s) begin
            case (bus.ADDR)
                A_DLO:   dout_s = data_q[7:0];
                A_DHI:   dout_s = data_q[15:8];
                A_CLO:   dout_s = cmd_q[7:0];
                A_CHI:   dout_s = cmd_q[15:8];
                A_CTL:   dout_s = {5'b00000, err_q, (state_q == ST_IDLE), rdone_q};
                default: dout_s = 8'h00;
            endcase
        end else begin
            dout_s = 8'h00;
        end
    end

    assign EECS     = eecs_q;
    assign EESK     = eesk_q;
    assign EEDI     = eedi_q;
    assign bus.DOE  = doe_s;
    assign bus.DOUT = dout_s;

endmodule

// File: tb/tb_bandai2003_eeprom_ctrl.sv
// Self-checking bench for bandai2003_eeprom_ctrl (CLK_DIV=2, CMD_BITS=11, POLL_MAX=64).
// Expected EEDI bits are queued when an op is launched and popped on each EESK rise.
module tb_bandai2003_eeprom_ctrl;
    localparam int CLK_DIV  = 2;
    localparam int CMD_BITS = 11;
    localparam int POLL_MAX = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic eecs, eesk, eedi, eedo;

    bandai2003_eeprom_ctrl_if bus_if ();

    bandai2003_eeprom_ctrl #(
        .CLK_DIV (CLK_DIV),
        .CMD_BITS(CMD_BITS),
        .POLL_MAX(POLL_MAX)
    ) dut (
        .CLK (clk),
        .RSTn(rst_n),
        .bus (bus_if),
        .EECS(eecs),
        .EESK(eesk),
        .EEDI(eedi),
        .EEDO(eedo)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    bit          exp_q[$];
    int          pulse_cnt = 0;
    int          pulse_base = 0;
    int          hi_run = 0;
    int          lo_run = 0;
    logic        sk_prev = 1'b0;
    bit          mon_hi_en = 1'b1;
    bit          rd_model = 1'b0;
    logic [15:0] rd_word = 16'h0000;
    bit          poll_lvl = 1'b0;
    int          rel;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // EEPROM model: read data on EEDO after the command bits, else the ready level
    always_comb begin
        rel  = pulse_cnt - pulse_base;
        eedo = poll_lvl;
        if (rd_model && rel >= 11 && rel <= 26) eedo = rd_word[26 - rel];
    end

    // Pin monitor: pulse count, EESK phase lengths and EEDI scoreboard
    always @(negedge clk) begin
        sk_prev <= eesk;
        if (eesk && !sk_prev) begin
            pulse_cnt <= pulse_cnt + 1;
            hi_run    <= 1;
            check_val("sk_low_len", lo_run, CLK_DIV);
            if (exp_q.size() > 0) check_val("eedi_bit", eedi, exp_q.pop_front());
        end else if (eesk) begin
            hi_run <= hi_run + 1;
        end else if (sk_prev && eecs && mon_hi_en) begin
            check_val("sk_high_len", hi_run, CLK_DIV);
        end
        if (eecs && !eesk) lo_run <= lo_run + 1;
        else               lo_run <= 0;
    end

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.SEL = 1'b1; bus_if.WEn = 1'b0; bus_if.OEn = 1'b1;
        bus_if.ADDR = a;   bus_if.DIN = d;
        @(negedge clk);
        bus_if.WEn = 1'b1; bus_if.SEL = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
        @(negedge clk);
        bus_if.SEL = 1'b1; bus_if.OEn = 1'b0; bus_if.ADDR = a;
        #1;
        d  = bus_if.DOUT;
        oe = bus_if.DOE;
        bus_if.OEn = 1'b1; bus_if.SEL = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        bus_rd(a, d, oe);
        check_val(tag, d, exp);
    endtask

    task automatic push_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    task automatic start_op(input string tag, input logic [15:0] cmd, input logic [7:0] ctl);
        bus_wr(8'hC6, cmd[7:0]);
        bus_wr(8'hC7, cmd[15:8]);
        pulse_base = pulse_cnt;
        bus_wr(8'hC8, ctl);
        check_val({tag, "_eecs_on"}, eecs, 1'b1);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        logic [7:0] d;
        logic       oe;
        bit         ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            bus_rd(8'hC8, d, oe);
            ok = d[1];
        end
        check_val({tag, "_ready"}, ok, 1'b1);
    endtask

    task automatic wait_pulses(input string tag, input int n, input int budget);
        int i = 0;
        while ((pulse_cnt - pulse_base) < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check_val({tag, "_pulses_seen"}, (pulse_cnt - pulse_base) >= n, 1'b1);
    endtask

    // Skip to the next EECS level 'lvl' and return how long it lasts
    task automatic measure_eecs(input logic lvl, input int budget, output int len);
        int g = 0;
        len = 0;
        while (eecs !== lvl && g < budget) begin @(negedge clk); g++; end
        while (eecs === lvl && len < budget) begin len++; @(negedge clk); end
    endtask

    initial begin
        int len;
        logic [7:0] d;
        logic       oe;
        bus_if.SEL = 1'b0; bus_if.WEn = 1'b1; bus_if.OEn = 1'b1;
        bus_if.ADDR = 8'h00; bus_if.DIN = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. reset state
        check_val("rst_eecs", eecs, 1'b0);
        check_val("rst_eesk", eesk, 1'b0);
        check_val("rst_eedi", eedi, 1'b0);
        bus_rd(8'hC8, d, oe);
        check_val("rst_c8", d, 8'h02);
        check_val("rst_doe", oe, 1'b1);
        rd_chk("rst_c4", 8'hC4, 8'h00);
        rd_chk("rst_c5", 8'hC5, 8'h00);
        rd_chk("rst_c6", 8'hC6, 8'h00);
        rd_chk("rst_c7", 8'hC7, 8'h00);
        @(negedge clk);
        bus_if.SEL = 1'b1; bus_if.ADDR = 8'hC8; bus_if.OEn = 1'b1;
        #1;
        check_val("doe_no_oe", bus_if.DOE, 1'b0);
        check_val("dout_no_oe", bus_if.DOUT, 8'h00);
        bus_if.SEL = 1'b0;

        // 2. read 0605h, EEPROM returns BEEFh
        rd_model = 1'b1; rd_word = 16'hBEEF;
        push_bits(16'h0605, CMD_BITS);
        start_op("rd", 16'h0605, 8'h10);
        wait_ready("rd", 300);
        check_val("rd_pulses", pulse_cnt - pulse_base, 27);
        check_val("rd_bits_left", exp_q.size(), 0);
        rd_chk("rd_c4", 8'hC4, 8'hEF);
        rd_chk("rd_c5", 8'hC5, 8'hBE);
        rd_chk("rd_c8", 8'hC8, 8'h03);
        rd_model = 1'b0;

        // 3. write 1234h, ready after 50 poll cycles
        bus_wr(8'hC4, 8'h34);
        bus_wr(8'hC5, 8'h12);
        push_bits(16'h0503, CMD_BITS);
        push_bits(16'h1234, 16);
        start_op("wr", 16'h0503, 8'h20);
        wait_pulses("wr", 27, 400);
        measure_eecs(1'b0, 50, len);
        check_val("wr_wgap_len", len, CLK_DIV);
        repeat (50) @(negedge clk);
        rd_chk("wr_poll_busy", 8'hC8, 8'h00);
        check_val("wr_poll_eecs", eecs, 1'b1);
        poll_lvl = 1'b1;
        wait_ready("wr", 50);
        poll_lvl = 1'b0;
        check_val("wr_pulses", pulse_cnt - pulse_base, 27);
        check_val("wr_bits_left", exp_q.size(), 0);
        rd_chk("wr_c8", 8'hC8, 8'h02);

        // 4. same write with EEDO stuck low
        push_bits(16'h0503, CMD_BITS);
        push_bits(16'h1234, 16);
        start_op("to", 16'h0503, 8'h20);
        wait_pulses("to", 27, 400);
        measure_eecs(1'b0, 50, len);
`ifdef EEP_POLL_TIMEOUT_EN
        measure_eecs(1'b1, 20000, len);
        check_val("to_poll_len", len, POLL_MAX);
        wait_ready("to", 50);
        rd_chk("to_c8", 8'hC8, 8'h06);
        check_val("to_eecs", eecs, 1'b0);
`else
        repeat (10000) @(negedge clk);
        rd_chk("to_still_busy", 8'hC8, 8'h00);
        check_val("to_eecs_held", eecs, 1'b1);
        bus_wr(8'hC8, 8'h80);
        check_val("to_abort_eecs", eecs, 1'b0);
        rd_chk("to_abort_c8", 8'hC8, 8'h02);
`endif

        // 5. abort a read after 5 pulses
        rd_model = 1'b1; rd_word = 16'hBEEF;
        push_bits(16'h0605, CMD_BITS);
        start_op("ab", 16'h0605, 8'h10);
        wait_pulses("ab", 5, 200);
        mon_hi_en = 1'b0;
        bus_wr(8'hC8, 8'h80);
        check_val("ab_eecs", eecs, 1'b0);
        check_val("ab_eesk", eesk, 1'b0);
        check_val("ab_eedi", eedi, 1'b0);
        exp_q.delete();
        rd_chk("ab_c8", 8'hC8, 8'h02);
        rd_chk("ab_c4", 8'hC4, 8'h34);
        rd_chk("ab_c5", 8'hC5, 8'h12);
        mon_hi_en = 1'b1;

        // 6. illegal start, then a data write while busy
        bus_wr(8'hC8, 8'h30);
        repeat (3) @(negedge clk);
        check_val("ill_eecs", eecs, 1'b0);
        rd_chk("ill_c8", 8'hC8, 8'h02);
        push_bits(16'h0605, CMD_BITS);
        start_op("busy", 16'h0605, 8'h10);
        wait_pulses("busy", 3, 200);
        bus_wr(8'hC4, 8'hAA);
        wait_ready("busy", 300);
        rd_chk("busy_c4", 8'hC4, 8'hEF);
        rd_chk("busy_c5", 8'hC5, 8'hBE);
        rd_chk("busy_c8", 8'hC8, 8'h03);
        rd_model = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
